// File: rtl/eac_norm_pkg.sv
// Shared constants and stage payload types for the EAC sum normalizer.
// Struct field widths follow the default datapath geometry below.
package eac_norm_pkg;

    localparam int unsigned NORM_DATA_WIDTH = 48;
    localparam int unsigned NORM_OUT_WIDTH  = 24;
    localparam int unsigned NORM_EXP_WIDTH  = 10;
    localparam int unsigned MAG_WIDTH       = NORM_DATA_WIDTH - 1;
    localparam int unsigned LZC_WIDTH       = $clog2(NORM_DATA_WIDTH);

    // S1 -> S2: recovered sign and magnitude
    typedef struct packed {
        logic                      sign;
        logic [MAG_WIDTH-1:0]      mag;
        logic [NORM_EXP_WIDTH-1:0] exp;
    } s1_payload_t;

    // S2 -> S3: magnitude plus its leading-zero count
    typedef struct packed {
        logic                      sign;
        logic [MAG_WIDTH-1:0]      mag;
        logic [NORM_EXP_WIDTH-1:0] exp;
        logic [LZC_WIDTH-1:0]      lzc;
        logic                      zero;
    } s2_payload_t;

endpackage

// File: rtl/eac_lzc.sv
// Combinational leading-zero counter built as a binary tree of 2:1 merges.
// count = WIDTH when the input is all zeros.
module eac_lzc #(
    parameter int unsigned WIDTH     = 47,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic [WIDTH-1:0]     din,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 all_zero
);

    localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned LEAVES = 1 << LEVELS;

    // Input is left-aligned in a power-of-two leaf row and padded with zeros
    // below, which cannot change the count of a non-zero value.
    always_comb begin : lzc_tree
        logic [LEAVES-1:0] padded;
        logic              z [0:LEVELS][0:LEAVES-1];
        logic [LEVELS-1:0] c [0:LEVELS][0:LEAVES-1];
        int unsigned       lv;

        padded = '0;
        padded[LEAVES-1 -: WIDTH] = din;
        lv = 0;
        for (int unsigned l = 0; l <= LEVELS; l++) begin
            for (int unsigned n = 0; n < LEAVES; n++) begin
                z[l][n] = 1'b1;
                c[l][n] = '0;
            end
        end
        for (int unsigned n = 0; n < LEAVES; n++) begin
            z[LEVELS][n] = ~padded[LEAVES-1-n];
        end
        for (int unsigned i = 0; i < LEVELS; i++) begin
            lv = LEVELS - 1 - i;
            for (int unsigned n = 0; n < (32'd1 << lv); n++) begin
                z[lv][n] = z[lv+1][2*n] & z[lv+1][2*n+1];
                c[lv][n] = z[lv+1][2*n]
                         ? (c[lv+1][2*n+1] | LEVELS'(32'd1 << (LEVELS - 1 - lv)))
                         : c[lv+1][2*n];
            end
        end
        all_zero = z[0][0];
        count    = all_zero ? CNT_WIDTH'(WIDTH) : CNT_WIDTH'(c[0][0]);
    end

endmodule

// File: rtl/eac_sum_normalizer.sv
// Three-stage elastic normalizer for the one's-complement EAC adder sum:
// S1 sign/complement, S2 leading-zero count, S3 shift and exponent adjust.
// Optional sticky output enabled by EAC_NORM_STICKY_EN.
module eac_sum_normalizer
    import eac_norm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = NORM_DATA_WIDTH,
    parameter int unsigned OUT_WIDTH  = NORM_OUT_WIDTH,
    parameter int unsigned EXP_WIDTH  = NORM_EXP_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_sum,
    input  logic [EXP_WIDTH-1:0]  in_exp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_mant,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic                  out_sign,
    output logic                  out_zero,
    output logic                  out_uflow,
    output logic                  out_sticky
);

    localparam int unsigned MAG_W = DATA_WIDTH - 1;

    s1_payload_t p1;
    s2_payload_t p2;
    logic v1, v2, v3;
    logic en1, en2, en3;

    logic [LZC_WIDTH-1:0] lzc_cnt;
    logic                 lzc_zero;

    logic [MAG_W-1:0]     sh;
    logic [EXP_WIDTH-1:0] lzc_ext;
    logic [OUT_WIDTH-1:0] s3_mant;
    logic [EXP_WIDTH-1:0] s3_exp;
    logic                 s3_sign;
    logic                 s3_uflow;

    // Stall chain: a stage loads when empty or when its successor loads
    always_comb begin
        en3      = !v3 || out_ready;
        en2      = !v2 || en3;
        en1      = !v1 || en2;
        in_ready = en1;
    end

    assign out_valid = v3;

    // S1: split sign and undo the one's-complement for negative sums
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            p1 <= '0;
        end else if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
                p1.sign <= in_sum[DATA_WIDTH-1];
                p1.mag  <= in_sum[DATA_WIDTH-1] ? ~in_sum[DATA_WIDTH-2:0]
                                                :  in_sum[DATA_WIDTH-2:0];
                p1.exp  <= in_exp;
            end
        end
    end

    eac_lzc #(
        .WIDTH     (MAG_W),
        .CNT_WIDTH (LZC_WIDTH)
    ) u_lzc (
        .din      (p1.mag),
        .count    (lzc_cnt),
        .all_zero (lzc_zero)
    );

    // S2: register the leading-zero count alongside the magnitude
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;
            p2 <= '0;
        end else if (en2) begin
            v2 <= v1;
            if (v1) begin
                p2.sign <= p1.sign;
                p2.mag  <= p1.mag;
                p2.exp  <= p1.exp;
                p2.lzc  <= lzc_cnt;
                p2.zero <= lzc_zero;
            end
        end
    end

    // S3 datapath: normalize, adjust exponent, flatten both zeros to +0
    always_comb begin
        sh       = p2.mag << p2.lzc;
        lzc_ext  = EXP_WIDTH'(p2.lzc);
        s3_mant  = sh[MAG_W-1 -: OUT_WIDTH];
        s3_exp   = p2.exp - lzc_ext;
        s3_uflow = lzc_ext > p2.exp;
        s3_sign  = p2.sign;
        if (p2.zero) begin
            s3_mant  = '0;
            s3_exp   = '0;
            s3_uflow = 1'b0;
            s3_sign  = 1'b0;
        end
    end

    // S3 output register, held while downstream stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3        <= 1'b0;
            out_mant  <= '0;
            out_exp   <= '0;
            out_sign  <= 1'b0;
            out_zero  <= 1'b0;
            out_uflow <= 1'b0;
        end else if (en3) begin
            v3 <= v2;
            if (v2) begin
                out_mant  <= s3_mant;
                out_exp   <= s3_exp;
                out_sign  <= s3_sign;
                out_zero  <= p2.zero;
                out_uflow <= s3_uflow;
            end
        end
    end

`ifdef EAC_NORM_STICKY_EN
    // Sticky: any magnitude bit shifted out below the retained mantissa
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sticky <= 1'b0;
        end else if (en3 && v2) begin
            out_sticky <= |sh[MAG_W-OUT_WIDTH-1:0];
        end
    end
`else
    logic unused_sh_low;
    assign unused_sh_low = |sh[MAG_W-OUT_WIDTH-1:0];
    assign out_sticky    = 1'b0;
`endif

endmodule
